// File: rtl/traffic_pkg.sv
// Shared types and default timings for the traffic controller.
// Durations are counted in prescaled ticks.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_t;

  localparam int DEF_GREEN_MIN = 4;
  localparam int DEF_GREEN_MAX = 12;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_ALLRED_T  = 1;

  function automatic int tmax3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/traffic_ctrl_n_rr_pick.sv
// Round-robin picker: first pending phase after the
// current one, wrapping around.
module rr_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt,
  output logic         valid
);

  int idx;

  // Scan farthest first so the nearest pending phase wins.
  always_comb begin
    nxt   = cur;
    valid = 1'b0;
    idx   = 0;
    for (int k = N - 1; k >= 1; k--) begin
      idx = (int'(cur) + k) % N;
      if (pending[idx]) begin
        nxt   = W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-phase traffic signal controller, adaptive or fixed
// rotation, with registered one-hot lamp drives.
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int TICK_DIV   = 16,
  parameter int GREEN_MIN  = DEF_GREEN_MIN,
  parameter int GREEN_MAX  = DEF_GREEN_MAX,
  parameter int YELLOW_T   = DEF_YELLOW_T,
  parameter int ALLRED_T   = DEF_ALLRED_T
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          test,
  input  logic                          fixed_mode,
  input  logic [NUM_PHASES-1:0]         req,
  output logic [NUM_PHASES-1:0]         grn,
  output logic [NUM_PHASES-1:0]         ylw,
  output logic [NUM_PHASES-1:0]         red,
  output logic [$clog2(NUM_PHASES)-1:0] phase
);

  localparam int N  = NUM_PHASES;
  localparam int W  = $clog2(N);
  localparam int TW =
    $clog2(tmax3(GREEN_MAX, YELLOW_T, ALLRED_T) + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [N-1:0] ONE = N'(1);

  state_t         state, state_n;
  logic [TW-1:0]  timer, timer_n;
  logic [PW-1:0]  presc;
  logic [N-1:0]   s1, s2, pending, pending_n;
  logic [N-1:0]   gmask, emask, g_n, y_n;
  logic [W-1:0]   nphase, nphase_n, phase_n;
  logic [W-1:0]   rr_nxt, succ;
  logic           rr_valid, tick;
  logic           t_ar, t_min, t_max, t_ylw;

  rr_pick #(.N(N), .W(W)) u_rr (
    .pending (pending),
    .cur     (phase),
    .nxt     (rr_nxt),
    .valid   (rr_valid)
  );

  assign tick  = test | (presc == PW'(TICK_DIV - 1));
  assign t_ar  = timer >= TW'(ALLRED_T - 1);
  assign t_min = timer >= TW'(GREEN_MIN - 1);
  assign t_max = timer >= TW'(GREEN_MAX - 1);
  assign t_ylw = timer >= TW'(YELLOW_T - 1);
  assign succ  = (phase == W'(N - 1)) ?
                 '0 : phase + W'(1);

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    nphase_n = nphase;
    unique case (state)
      ALLRED: if (tick && t_ar) begin
        state_n = GREEN;
        phase_n = nphase;
      end
      GREEN: if (tick) begin
        if (fixed_mode) begin
          if (t_max) begin
            state_n  = YELLOW;
            nphase_n = succ;
          end
        end else if (rr_valid &&
                     (t_max || (t_min && !s2[phase]))) begin
          state_n  = YELLOW;
          nphase_n = rr_nxt;
        end
      end
      YELLOW: if (tick && t_ylw) state_n = ALLRED;
      default: state_n = ALLRED;
    endcase
    if (clr) begin
      state_n  = ALLRED;
      phase_n  = '0;
      nphase_n = '0;
    end
  end

  // Served phase never latches its own request.
  always_comb begin
    gmask = (state == GREEN) ? (ONE << phase) : '0;
    emask = (state != GREEN && state_n == GREEN) ?
            (ONE << phase_n) : '0;
    pending_n = (pending | (s2 & ~gmask)) & ~emask;
    timer_n   = timer;
    if (state_n != state) timer_n = '0;
    else if (tick && timer != '1) timer_n = timer + TW'(1);
    if (clr) begin
      timer_n   = '0;
      pending_n = '0;
    end
    g_n = (state_n == GREEN)  ? (ONE << phase_n) : '0;
    y_n = (state_n == YELLOW) ? (ONE << phase_n) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ALLRED;
      timer   <= '0;
      presc   <= '0;
      s1      <= '0;
      s2      <= '0;
      pending <= '0;
      phase   <= '0;
      nphase  <= '0;
      grn     <= '0;
      ylw     <= '0;
      red     <= '1;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      presc   <= (presc == PW'(TICK_DIV - 1)) ?
                 '0 : presc + PW'(1);
      s1      <= req;
      s2      <= s1;
      pending <= pending_n;
      phase   <= phase_n;
      nphase  <= nphase_n;
      grn     <= g_n;
      ylw     <= y_n;
      red     <= ~(g_n | y_n);
    end
  end

endmodule
